// File: rtl/dumbrv_stray_pkg.sv
// Shared types for the stray-bus arbiter: FSM states, slot ids,
// decode bases and the latched command bundle.
package dumbrv_stray_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   typedef logic [1:0] slot_t;

   localparam slot_t SLOT_GPIO = 2'd0;
   localparam slot_t SLOT_TMR  = 2'd1;
   localparam slot_t SLOT_NONE = 2'd2;

   localparam logic [11:0] BASE_GPIO = 12'hFFF;
   localparam logic [11:0] BASE_TMR  = 12'hFFE;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } cmd_t;

   function automatic slot_t decode(input logic [15:0] a);
      if (a[15:4] == BASE_GPIO)
         return SLOT_GPIO;
      else if (a[15:4] == BASE_TMR)
         return SLOT_TMR;
      else
         return SLOT_NONE;
   endfunction

   function automatic logic [1:0] slot_onehot(input slot_t s);
      case (s)
         SLOT_GPIO: return 2'b01;
         SLOT_TMR:  return 2'b10;
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dumbrv_stray_arb_if.sv
// Requester-side stray-bus port: level request in, registered
// completion pulse with read data and error out.
interface dumbrv_stray_arb_if;
   logic        req;
   logic        wr;
   logic [15:0] addr;
   logic [2:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        err;

   modport master (
      output req, wr, addr, size, wdata,
      input  rdata, done, err
   );

   modport slave (
      input  req, wr, addr, size, wdata,
      output rdata, done, err
   );
endinterface

// File: rtl/dumbrv_stray_rr.sv
// Two-way round-robin picker; last-grant pointer comes out of
// reset pointing at m1 so m0 wins the first tie.
module dumbrv_stray_rr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_id,
   output logic       gnt_id
);

   logic last;

   always_comb begin
      gnt_id = 1'b0;
      unique case (1'b1)
         (req == 2'b11): gnt_id = ~last;
         (req == 2'b10): gnt_id = 1'b1;
         default:        gnt_id = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= 1'b1;
      else if (upd)
         last <= upd_id;
   end

endmodule

// File: rtl/dumbrv_stray_arb.sv
// Stray-bus arbiter/decoder: two requesters, GPIO and timer slots,
// with unmapped and timeout completions flagged as errors.
module dumbrv_stray_arb
   import dumbrv_stray_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   dumbrv_stray_arb_if.slave  m0,
   dumbrv_stray_arb_if.slave  m1,
   output logic [1:0]         s_en,
   output logic               s_wr,
   output logic [15:0]        s_addr,
   output logic [2:0]         s_size,
   output logic [31:0]        s_wdata,
   input  logic [31:0]        s0_rdata,
   input  logic [31:0]        s1_rdata,
   input  logic               s0_done,
   input  logic               s1_done
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          st;
   cmd_t            cmd;
   cmd_t            nxt;
   slot_t           slot;
   logic            win;
   logic            gnt;
   logic [TO_W-1:0] cnt;
   logic [31:0]     rdata;
   logic            err;
   logic            done;
   logic            sel_done;
   logic [31:0]     sel_rdata;

   dumbrv_stray_rr u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({m1.req, m0.req}),
      .upd    (st == ST_RESP),
      .upd_id (win),
      .gnt_id (gnt)
   );

   always_comb begin
      nxt.wr    = gnt ? m1.wr    : m0.wr;
      nxt.addr  = gnt ? m1.addr  : m0.addr;
      nxt.size  = gnt ? m1.size  : m0.size;
      nxt.wdata = gnt ? m1.wdata : m0.wdata;
   end

   always_comb begin
      sel_done  = 1'b0;
      sel_rdata = '0;
      unique case (1'b1)
         (slot == SLOT_GPIO): begin
            sel_done  = s0_done;
            sel_rdata = s0_rdata;
         end
         (slot == SLOT_TMR): begin
            sel_done  = s1_done;
            sel_rdata = s1_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= ST_IDLE;
         cmd   <= '0;
         slot  <= SLOT_NONE;
         win   <= 1'b0;
         cnt   <= '0;
         rdata <= '0;
         err   <= 1'b0;
         done  <= 1'b0;
         s_en  <= 2'b00;
      end else begin
         unique case (st)
            ST_IDLE: begin
               if (m0.req || m1.req) begin
                  cmd  <= nxt;
                  win  <= gnt;
                  slot <= decode(nxt.addr);
                  s_en <= slot_onehot(decode(nxt.addr));
                  cnt  <= '0;
                  st   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (slot != SLOT_NONE && sel_done) begin
                  rdata <= sel_rdata;
                  err   <= 1'b0;
                  done  <= 1'b1;
                  s_en  <= 2'b00;
                  st    <= ST_RESP;
               end else if (slot == SLOT_NONE || cnt == TO_LAST) begin
                  rdata <= '0;
                  err   <= 1'b1;
                  done  <= 1'b1;
                  s_en  <= 2'b00;
                  st    <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               rdata <= '0;
               err   <= 1'b0;
               done  <= 1'b0;
               cnt   <= '0;
               st    <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   // Command bus is zeroed whenever no slot is enabled
   assign s_wr    = (|s_en) & cmd.wr;
   assign s_addr  = (|s_en) ? cmd.addr  : '0;
   assign s_size  = (|s_en) ? cmd.size  : '0;
   assign s_wdata = (|s_en) ? cmd.wdata : '0;

   assign m0.done  = done & ~win;
   assign m0.err   = err  & ~win;
   assign m0.rdata = (done & ~win) ? rdata : '0;
   assign m1.done  = done & win;
   assign m1.err   = err  & win;
   assign m1.rdata = (done & win) ? rdata : '0;

endmodule

// File: tb/tb_dumbrv_stray_arb.sv
// Randomized bench for the stray-bus arbiter against a
// transaction-level model of grant order, latency and response.
module tb_dumbrv_stray_arb;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dumbrv_stray_arb_if m0_if ();
   dumbrv_stray_arb_if m1_if ();

   logic [1:0]  s_en;
   logic        s_wr;
   logic [15:0] s_addr;
   logic [2:0]  s_size;
   logic [31:0] s_wdata;
   logic [31:0] s0_rdata, s1_rdata;
   logic        s0_done, s1_done;

   dumbrv_stray_arb #(.TIMEOUT(TO), .TO_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0       (m0_if),
      .m1       (m1_if),
      .s_en     (s_en),
      .s_wr     (s_wr),
      .s_addr   (s_addr),
      .s_size   (s_size),
      .s_wdata  (s_wdata),
      .s0_rdata (s0_rdata),
      .s1_rdata (s1_rdata),
      .s0_done  (s0_done),
      .s1_done  (s1_done)
   );

   logic        req   [2];
   logic        wr    [2];
   logic [15:0] addr  [2];
   logic [2:0]  size  [2];
   logic [31:0] wdata [2];
   logic [31:0] rd    [2];
   logic [1:0]  dn, er;

   assign m0_if.req   = req[0];
   assign m0_if.wr    = wr[0];
   assign m0_if.addr  = addr[0];
   assign m0_if.size  = size[0];
   assign m0_if.wdata = wdata[0];
   assign m1_if.req   = req[1];
   assign m1_if.wr    = wr[1];
   assign m1_if.addr  = addr[1];
   assign m1_if.size  = size[1];
   assign m1_if.wdata = wdata[1];
   assign rd[0] = m0_if.rdata;
   assign rd[1] = m1_if.rdata;
   assign dn = {m1_if.done, m0_if.done};
   assign er = {m1_if.err, m0_if.err};

   // GPIO slave: always ready; timer slave: done after t_lat en cycles
   logic [31:0] gpio_i, t_val;
   logic [31:0] gpio_o = '0;
   int t_lat;
   int t_cnt = 0;

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] d,
                                         input logic [2:0] sz);
      case (sz)
         3'd1:    return {o[31:8], d[7:0]};
         3'd2:    return {o[31:16], d[15:0]};
         default: return d;
      endcase
   endfunction

   assign s0_rdata = gpio_i;
   assign s0_done  = 1'b1;
   assign s1_rdata = t_val;
   assign s1_done  = s_en[1] && (t_lat != 0) && (t_cnt + 1 >= t_lat);

   always @(posedge clk) begin
      if (s_en[0] && s_wr)
         gpio_o <= merge(gpio_o, s_wdata, s_size);
      t_cnt <= s_en[1] ? t_cnt + 1 : 0;
   end

   int n_vec = 0;
   int n_bad = 0;
   int last_g = 1;
   logic [1:0] pend = 2'b00;
   logic [31:0] exp_gpio = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int i, input logic w, input logic [15:0] a,
                        input logic [2:0] sz, input logic [31:0] d);
      wr[i] = w;
      addr[i] = a;
      size[i] = sz;
      wdata[i] = d;
      req[i] = 1'b1;
      pend[i] = 1'b1;
   endtask

   task automatic rand_m(input int i);
      logic [15:0] a;
      logic [2:0] sz;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
         0: a[15:4] = 12'hFFF;
         1: a[15:4] = 12'hFFE;
         default: ;
      endcase
      case ($urandom_range(0, 2))
         0: sz = 3'd1;
         1: sz = 3'd2;
         default: sz = 3'd4;
      endcase
      set_m(i, 1'($urandom), a, sz, $urandom);
   endtask

   // One granted access, from the IDLE cycle where reqs are sampled
   task automatic do_one(input bit drop);
      int w, busy, c, en_cnt;
      logic [1:0] e_en;
      logic [31:0] e_rd;
      logic e_err;
      bit got;
      w = (pend == 2'b11) ? 1 - last_g : (pend[0] ? 0 : 1);
      if (addr[w][15:4] == 12'hFFF) begin
         e_en = 2'b01; busy = 1; e_rd = gpio_i; e_err = 1'b0;
      end else if (addr[w][15:4] == 12'hFFE) begin
         e_en = 2'b10;
         if (t_lat >= 1 && t_lat <= TO) begin
            busy = t_lat; e_rd = t_val; e_err = 1'b0;
         end else begin
            busy = TO; e_rd = '0; e_err = 1'b1;
         end
      end else begin
         e_en = 2'b00; busy = 1; e_rd = '0; e_err = 1'b1;
      end
      got = 0;
      c = 0;
      en_cnt = 0;
      while (!got && c < 3 * TO + 10) begin
         @(negedge clk);
         c++;
         if (drop && c == 1)
            req[w] = 1'b0;
         if (s_en != 2'b00) begin
            en_cnt++;
            chk("s_en", 32'(s_en), 32'(e_en));
            chk("s_addr", 32'(s_addr), 32'(addr[w]));
            chk("s_wr", 32'(s_wr), 32'(wr[w]));
            chk("s_size", 32'(s_size), 32'(size[w]));
            chk("s_wdata", s_wdata, wdata[w]);
         end
         if (dn != 2'b00) begin
            got = 1;
            chk("done_who", 32'(dn), (w == 0) ? 32'd1 : 32'd2);
            chk("latency", 32'(c), 32'(busy + 1));
            chk("rdata", rd[w], e_rd);
            chk("err", 32'(er[w]), 32'(e_err));
            chk("loser_rdata", rd[1 - w], 32'd0);
            chk("loser_err", 32'(er[1 - w]), 32'd0);
            chk("en_cycles", 32'(en_cnt), (e_en != 0) ? 32'(busy) : 32'd0);
         end
      end
      if (!got)
         chk("done_timeout", 32'd0, 32'd1);
      req[w] = 1'b0;
      pend[w] = 1'b0;
      last_g = w;
      if (e_en == 2'b01 && wr[w])
         exp_gpio = merge(exp_gpio, wdata[w], size[w]);
      @(negedge clk);
      chk("idle_en", 32'(s_en), 32'd0);
      chk("idle_done", 32'(dn), 32'd0);
      chk("gpio_o", gpio_o, exp_gpio);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0;
         size[i] = '0; wdata[i] = '0;
      end
      gpio_i = '0;
      t_val = '0;
      t_lat = 1;
      repeat (2) @(negedge clk);
      chk("rst_s_en", 32'(s_en), 32'd0);
      chk("rst_done", 32'(dn), 32'd0);
      chk("rst_err", 32'(er), 32'd0);
      chk("rst_rd0", rd[0], 32'd0);
      chk("rst_rd1", rd[1], 32'd0);
      chk("rst_bus", 32'(s_addr) | s_wdata | 32'(s_size) | 32'(s_wr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // tie right after reset: m0 first, then m1
      gpio_i = 32'h3C; t_val = 32'h1234_5678; t_lat = 2;
      set_m(0, 1'b0, 16'hFFFF, 3'd4, 32'h0);
      set_m(1, 1'b0, 16'hFFE0, 3'd4, 32'h0);
      do_one(0);
      do_one(0);
      set_m(0, 1'b1, 16'hFFFF, 3'd1, 32'h0000_00A5);
      do_one(0);
      chk("gpio_a5", gpio_o, 32'hA5);
      // second tie after m0 was served alone: m1 first
      t_lat = 1;
      set_m(0, 1'b0, 16'hFFF4, 3'd2, 32'h0);
      set_m(1, 1'b0, 16'hFFE8, 3'd4, 32'h0);
      do_one(0);
      do_one(0);
      set_m(1, 1'b0, 16'h1234, 3'd4, 32'h0);
      do_one(0);
      t_lat = 0;
      set_m(0, 1'b0, 16'hFFE4, 3'd4, 32'h0);
      do_one(0);
      set_m(0, 1'b0, 16'hFFF0, 3'd4, 32'h0);
      do_one(1);

      // reset during BUSY aborts the access with no done
      t_lat = 0;
      set_m(0, 1'b0, 16'hFFE0, 3'd4, 32'h0);
      @(negedge clk);
      chk("pre_rst_en", 32'(s_en), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", 32'(s_en), 32'd0);
      chk("arst_done", 32'(dn), 32'd0);
      req[0] = 1'b0;
      pend = 2'b00;
      last_g = 1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(dn), 32'd0);
      end
      gpio_i = 32'h5A;
      set_m(0, 1'b0, 16'hFFFC, 3'd4, 32'h0);
      do_one(0);

      for (int it = 0; it < 200; it++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1)
               rand_m(i);
         gpio_i = $urandom;
         t_val = $urandom;
         t_lat = $urandom_range(0, TO + 2);
         if (pend == 2'b00) begin
            @(negedge clk);
            chk("quiet_en", 32'(s_en), 32'd0);
         end else begin
            do_one($urandom_range(0, 3) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dumbrv_stray_arb.md
# dumbrv_stray_arb

Arbiter and decoder for the stray memory bus, placed between two requesters (core stray port m0, debug/loader port m1) and up to two stray-bus peripherals: slot 0 = GPIO, slot 1 = timer. It grants one requester at a time with round-robin fairness, routes the access to the decoded slot, and returns read data and completion. Accesses to unmapped or unresponsive addresses complete with zero data and an error flag.

## Interface
- TIMEOUT, 15: max BUSY cycles waiting for slave done (1..255)
- TO_W, 8: timeout counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request, level, held until done
- m0_wr / m1_wr  in  1  1 = write
- m0_addr / m1_addr  in  16  byte address
- m0_size / m1_size  in  3  access size in bytes (1, 2, 4)
- m0_wdata / m1_wdata  in  32  write data
- m0_rdata / m1_rdata  out  32  read data, valid while done is high
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  error qualifier, valid with done
- s_en  out  2  one-hot slot enable
- s_wr, s_addr[15:0], s_size[2:0], s_wdata[31:0]  out  shared slave command bus
- s0_rdata / s1_rdata  in  32  slave read data
- s0_done / s1_done  in  1  slave done (may be combinational, may be constant 1)

## Operation
- Decode on addr[15:4]: 12'hFFF → slot 0, 12'hFFE → slot 1, else unmapped.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req is high, pick a winner; latch wr/addr/size/wdata, winner id and decoded slot; → BUSY.
- Round-robin: one requesting → it wins; both → the one not granted last. Last-grant pointer resets to m1, so m0 wins the first tie.
- BUSY: s_en[slot] = 1, shared command bus driven from latched values; counter increments every cycle.
  - selected s*_done high → capture rdata, err = 0, → RESP.
  - unmapped → s_en = 0, rdata = 0, err = 1, → RESP after exactly one BUSY cycle.
  - counter reaches TIMEOUT−1 without done → rdata = 0, err = 1, → RESP; s_en drops.
- RESP: winner's done = 1 for one cycle with registered rdata and err; loser's outputs stay 0; update last-grant pointer; → IDLE.
- Requester deasserting req mid-transaction is ignored; the transaction completes and done still pulses.
- Requester must drive req low in the cycle after its done unless a new access is intended; a high req in that IDLE cycle starts a new access.
- Command-bus values are don't-care while s_en = 0; the implementation drives zeros.

## Timing
- Reset: state IDLE, s_en = 0, all done/err = 0, all rdata = 0, command bus 0, counter 0, pointer = m1.
- Latency for a single-cycle slave (GPIO): req sampled in cycle N (IDLE), s_en high in N+1, done in N+2.
- Slave with k-cycle done: done at N+1+k. Timeout: done at N+1+TIMEOUT.
- s_en is held for every BUSY cycle; a slave may act on each cycle of en and must be idempotent.
- Back-to-back throughput: one access per 3 cycles.
- Reset asserted mid-operation returns all outputs to reset values immediately. No done is issued for the aborted access.

## Structure
- Package dumbrv_stray_pkg holds the following:
  - state enum
  - slot id constants
  - decode bases 12'hFFF and 12'hFFE
  - typedef of the latched command (wr, addr, size, wdata)
- Sub-module dumbrv_stray_rr is a 2-way round-robin picker with a registered last-grant pointer and an update strobe from RESP.

## Test plan
- m0 writes 0x000000A5, size 1, to 0xFFFF: s_en = 2'b01 one cycle at N+1; m0_done at N+2 with err = 0; GPIO output reads back 0xA5.
- m0 and m1 request together, m0 reads 0xFFFF with gpio_i = 0x3C, m1 reads 0xFFE0: m0 completes first with rdata 0x0000003C, then m1; a second tie grants m1 first.
- m1 reads 0x1234: no s_en pulse; m1_done at N+2 with rdata 0 and err = 1.
- Slot 1 done tied low, TIMEOUT = 4: s_en[1] high 4 cycles; done at N+5 with err = 1 and rdata 0.
- rst_n pulsed low during BUSY: s_en and done drop asynchronously; no done after release; next m0 access completes normally.
- m0 drops req one cycle into BUSY: m0_done still pulses at N+2; no new access starts.
